// File: rtl/ftdi_pkg.sv
// Shared types and constants for the FTDI-style FIFO responder.
// Read/write handshake states and byte width live here.
package ftdi_pkg;
  localparam int FTDI_BYTE_W = 8;
  localparam int FTDI_DEPTH  = 128;

  typedef enum logic [1:0] {
    R_IDLE,
    R_DRIVE,
    R_RECOVER
  } rd_state_t;

  typedef enum logic [1:0] {
    W_IDLE,
    W_WAIT,
    W_RECOVER
  } wr_state_t;
endpackage

// File: rtl/byte_fifo.sv
// Synchronous show-ahead byte FIFO with exact occupancy count.
// Push when full and pop when empty are ignored.
module byte_fifo
  import ftdi_pkg::*;
#(
  parameter int DEPTH = FTDI_DEPTH,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   push,
  input  logic [FTDI_BYTE_W-1:0] data,
  input  logic                   pop,
  output logic [FTDI_BYTE_W-1:0] head,
  output logic [CW-1:0]          count,
  output logic                   full,
  output logic                   empty
);
  logic [FTDI_BYTE_W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic do_push;
  logic do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= data;
  end

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/ftdi_fifo_responder.sv
// Device side of an FTDI async FIFO bus: host strobes rd_n/wr_n
// move bytes between the bus and local RX/TX FIFOs.
module ftdi_fifo_responder
  import ftdi_pkg::*;
#(
  parameter int DEPTH = FTDI_DEPTH,
  parameter int SYNC_STAGES = 2,
  parameter int RECOVER_CYCLES = 2,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   rd_n,
  input  logic                   wr_n,
  output logic                   rxf_n,
  output logic                   txe_n,
  input  logic [FTDI_BYTE_W-1:0] adbus_in,
  output logic [FTDI_BYTE_W-1:0] adbus_out,
  output logic                   adbus_oe,
  input  logic [FTDI_BYTE_W-1:0] src_data,
  input  logic                   src_valid,
  output logic                   src_ready,
  output logic [FTDI_BYTE_W-1:0] snk_data,
  output logic                   snk_valid,
  input  logic                   snk_ready,
  output logic [CW-1:0]          rx_count,
  output logic [CW-1:0]          tx_count,
  output logic                   err_overrun
);
  localparam int RCW = (RECOVER_CYCLES > 1) ? $clog2(RECOVER_CYCLES) : 1;
  localparam logic [RCW-1:0] REC_INIT = RCW'(RECOVER_CYCLES - 1);

  logic [SYNC_STAGES-1:0] rd_sync;
  logic [SYNC_STAGES-1:0] wr_sync;
  logic [FTDI_BYTE_W-1:0] d_sync [SYNC_STAGES];
  logic rd_prev;
  logic wr_prev;
  logic rd_s;
  logic wr_s;
  logic [FTDI_BYTE_W-1:0] d_s;
  logic rd_fall;
  logic rd_rise;
  logic wr_fall;
  logic wr_rise;

  rd_state_t rstate;
  wr_state_t wstate;
  logic [RCW-1:0] rcnt;
  logic [RCW-1:0] wcnt;

  logic [FTDI_BYTE_W-1:0] rx_head;
  logic rx_full;
  logic rx_empty;
  logic tx_full;
  logic tx_empty;
  logic rx_pop;
  logic tx_push;
  logic w_ok;

  assign rd_s    = rd_sync[SYNC_STAGES-1];
  assign wr_s    = wr_sync[SYNC_STAGES-1];
  assign d_s     = d_sync[SYNC_STAGES-1];
  assign rd_fall = rd_prev && !rd_s;
  assign rd_rise = !rd_prev && rd_s;
  assign wr_fall = wr_prev && !wr_s;
  assign wr_rise = !wr_prev && wr_s;

  assign rx_pop  = (rstate == R_DRIVE) && rd_rise;
  assign tx_push = (wstate == W_WAIT) && wr_rise;
  // A write only starts when the bus is not, and is not about to be, driven.
  assign w_ok    = (wstate == W_IDLE) && !txe_n &&
                   (rstate == R_IDLE) && !rd_fall;

  assign src_ready = !rx_full;
  assign snk_valid = !tx_empty;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_sync <= '1;
      wr_sync <= '1;
      for (int i = 0; i < SYNC_STAGES; i++) d_sync[i] <= '1;
      rd_prev <= 1'b1;
      wr_prev <= 1'b1;
    end else begin
      rd_sync[0] <= rd_n;
      wr_sync[0] <= wr_n;
      d_sync[0]  <= adbus_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        rd_sync[i] <= rd_sync[i-1];
        wr_sync[i] <= wr_sync[i-1];
        d_sync[i]  <= d_sync[i-1];
      end
      rd_prev <= rd_s;
      wr_prev <= wr_s;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rstate    <= R_IDLE;
      rcnt      <= '0;
      rxf_n     <= 1'b1;
      adbus_oe  <= 1'b0;
      adbus_out <= '0;
    end else begin
      case (rstate)
        R_IDLE: begin
          if (rd_fall && !rxf_n) begin
            rstate    <= R_DRIVE;
            adbus_oe  <= 1'b1;
            adbus_out <= rx_head;
          end else begin
            rxf_n <= rx_empty;
          end
        end
        R_DRIVE: begin
          if (rd_rise) begin
            rstate   <= R_RECOVER;
            adbus_oe <= 1'b0;
            rxf_n    <= 1'b1;
            rcnt     <= REC_INIT;
          end
        end
        R_RECOVER: begin
          if (rcnt == '0) rstate <= R_IDLE;
          else            rcnt   <= rcnt - 1'b1;
        end
        default: rstate <= R_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wstate      <= W_IDLE;
      wcnt        <= '0;
      txe_n       <= 1'b1;
      err_overrun <= 1'b0;
    end else begin
      if (wr_fall && !w_ok) err_overrun <= 1'b1;
      case (wstate)
        W_IDLE: begin
          if (wr_fall && w_ok) begin
            wstate <= W_WAIT;
            txe_n  <= 1'b1;
          end else begin
            txe_n <= tx_full;
          end
        end
        W_WAIT: begin
          if (wr_rise) begin
            wstate <= W_RECOVER;
            wcnt   <= REC_INIT;
          end
        end
        W_RECOVER: begin
          if (wcnt == '0) wstate <= W_IDLE;
          else            wcnt   <= wcnt - 1'b1;
        end
        default: wstate <= W_IDLE;
      endcase
    end
  end

  byte_fifo #(.DEPTH(DEPTH)) u_rx (
    .clock (clock),
    .reset (reset),
    .push  (src_valid),
    .data  (src_data),
    .pop   (rx_pop),
    .head  (rx_head),
    .count (rx_count),
    .full  (rx_full),
    .empty (rx_empty)
  );

  byte_fifo #(.DEPTH(DEPTH)) u_tx (
    .clock (clock),
    .reset (reset),
    .push  (tx_push),
    .data  (d_s),
    .pop   (snk_ready),
    .head  (snk_data),
    .count (tx_count),
    .full  (tx_full),
    .empty (tx_empty)
  );
endmodule

// File: doc/ftdi_fifo_responder.md
FTDI_FIFO_RESPONDER -- requirements
Module: ftdi_fifo_responder

Interface
REQ-001 Parameter DEPTH, default 128: RX and TX FIFO depth in bytes, power of two, 2..256.
REQ-002 Parameter SYNC_STAGES, default 2: synchronizer flops on rd_n, wr_n and adbus_in.
REQ-003 Parameter RECOVER_CYCLES, default 2: clocks rxf_n/txe_n held high after each byte.
REQ-004 clock  input  1  single clock, all logic rising-edge.
REQ-005 reset  input  1  asynchronous, active-high.
REQ-006 rd_n  input  1  host read strobe, active low, asynchronous to clock.
REQ-007 wr_n  input  1  host write strobe, active low, asynchronous to clock.
REQ-008 rxf_n  output  1  low = byte available for host to read.
REQ-009 txe_n  output  1  low = host may write a byte.
REQ-010 adbus_in  input  8  data bus as driven by host.
REQ-011 adbus_out  output  8  data driven toward host.
REQ-012 adbus_oe  output  1  bus output enable.
REQ-013 src_data / src_valid / src_ready  8/1 in, 1 out  local push into RX FIFO (bytes to host).
REQ-014 snk_data / snk_valid out, snk_ready in  8/1/1  local pop from TX FIFO (bytes from host).
REQ-015 rx_count, tx_count  output  $clog2(DEPTH)+1  FIFO occupancies.
REQ-016 err_overrun  output  1  sticky: host strobe ignored (wr_n while txe_n high, or bus collision).

Function
REQ-017 rd_n, wr_n and adbus_in SHALL pass through SYNC_STAGES flops; edges detected on synchronized values.
REQ-018 Read FSM states R_IDLE, R_DRIVE, R_RECOVER.
REQ-019 R_IDLE -> R_DRIVE on synchronized rd_n fall while rxf_n low; adbus_oe=1, adbus_out=RX head, registered, valid SYNC_STAGES+1 clocks after rd_n fall.
REQ-020 R_DRIVE -> R_RECOVER on synchronized rd_n rise: adbus_oe=0 next clock, RX pop that clock, rxf_n=1.
REQ-021 R_RECOVER lasts RECOVER_CYCLES clocks, then R_IDLE; rxf_n low in R_IDLE iff RX not empty.
REQ-022 rd_n fall with rxf_n high SHALL be ignored: adbus_oe stays 0, no pop, no error.
REQ-023 Write FSM states W_IDLE, W_WAIT, W_RECOVER; txe_n low only in W_IDLE with TX not full.
REQ-024 W_IDLE -> W_WAIT on synchronized wr_n fall with txe_n low; txe_n=1.
REQ-025 W_WAIT -> W_RECOVER on synchronized wr_n rise: push synchronized adbus_in sampled that clock into TX.
REQ-026 W_RECOVER lasts RECOVER_CYCLES clocks, then W_IDLE.
REQ-027 wr_n fall with txe_n high SHALL drop the byte and set err_overrun.
REQ-028 Collision: wr_n fall while read FSM not R_IDLE, or rd_n and wr_n falling same clock -> read proceeds, write dropped, err_overrun set.
REQ-029 src_ready = RX not full (registered count); push when src_valid&&src_ready.
REQ-030 snk_valid = TX not empty, snk_data = TX head (show-ahead); pop when snk_valid&&snk_ready.
REQ-031 Simultaneous push and pop on a FIFO SHALL both occur, count unchanged; on full FIFO the push is refused (src_ready already 0).
REQ-032 Counts exact 0..DEPTH; pointers wrap modulo DEPTH without data loss.

Reset
REQ-033 While reset high: rxf_n=1, txe_n=1, adbus_oe=0, adbus_out=0, snk_valid=0, src_ready=1, counts=0, err_overrun=0, FSMs R_IDLE/W_IDLE, synchronizers=1 (strobes idle).
REQ-034 Reset mid-cycle SHALL drop adbus_oe combinationally-asynchronously via flop reset; in-flight byte discarded, FIFOs emptied.

Structure
REQ-035 Package ftdi_pkg: read/write state enums, FTDI_BYTE_W=8, default DEPTH.
REQ-036 One sub-module byte_fifo (synchronous show-ahead FIFO with count), instantiated for RX and TX.

Verification
REQ-037 Push 0x01,0x02,0x03; host pulses rd_n thrice -> adbus_out 01,02,03 while adbus_oe=1; rxf_n high >=2 clocks between bytes, high after third.
REQ-038 Push 128 bytes without reads -> rx_count=128, src_ready=0; 129th byte refused; then rd of one byte -> src_ready=1.
REQ-039 Host writes 0xA5 -> snk_valid=1, snk_data=0xA5, tx_count=1; 128 writes with snk_ready=0 -> txe_n stays high; extra wr_n -> err_overrun=1.
REQ-040 rd_n low with RX empty -> adbus_oe never 1, rxf_n stays 1.
REQ-041 Reset pulse during R_DRIVE -> adbus_oe=0, rxf_n=1, rx_count=0 immediately.
REQ-042 Two packets of bytes 1..127 pushed, host reads each with rd_n handshake -> 254 bytes received in order, no err_overrun.
